imem_loader: RTL
================

// Module: imem_loader
// PURPOSE
//  Write-side counterpart of the instruction memory: receives a program image as a
//  byte stream (e.g. from a UART RX or testbench) and writes it as 32-bit words into
//  instruction memory starting at BASE_ADDR. Holds the core in reset (cpu_hold) while
//  loading, so fetch starts at PC 0 on a fully written image.
// PARAMETERS
//  BASE_ADDR  32'h0     byte address of the first word written (must be 4-byte aligned)
//  MAX_WORDS  1024      largest accepted image length in words; larger header -> error
//  CNT_W      16        width of word counter / header length field used (LSBs of header)
// PORTS
//  clk          in   1      clock
//  reset        in   1      reset, asynchronous, active-high
//  start        in   1      pulse: begin a load (accepted in IDLE, DONE, ERROR only)
//  byte_valid   in   1      byte_data valid
//  byte_data    in   8      stream byte
//  byte_ready   out  1      loader accepts byte this cycle (byte_valid & byte_ready)
//  mem_we       out  1      write request to instruction memory
//  mem_addr     out  32     byte address of write (BASE_ADDR + 4*index)
//  mem_wdata    out  32     assembled instruction word
//  mem_ready    in   1      memory accepts write this cycle (mem_we & mem_ready)
//  cpu_hold     out  1      high while a load is in progress
//  done         out  1      sticky: last load completed OK
//  error        out  1      sticky: last load aborted
//  words_written out CNT_W  count of words committed in current/last load
// BEHAVIOUR
//  Reset: state=IDLE; byte_ready, mem_we, cpu_hold, done, error = 0; mem_addr=BASE_ADDR;
//   mem_wdata=0; words_written=0. Async reset mid-load abandons the load immediately.
//  States: IDLE, HDR, DATA, WRITE, CHK (CHECKSUM_EN only), DONE, ERROR.
//  IDLE/DONE/ERROR --start--> HDR; clears done, error, words_written, byte counter.
//   start in any other state is ignored.
//  HDR: byte_ready=1; 4 bytes, little-endian, form length N. After 4th byte:
//   N==0 -> DONE; N>MAX_WORDS -> ERROR; else -> DATA.
//  DATA: byte_ready=1; 4 bytes, little-endian (first byte -> wdata[7:0]). On 4th byte
//   accept, next cycle: state=WRITE, mem_we=1, mem_wdata=word, mem_addr=BASE_ADDR+4*idx.
//  WRITE: byte_ready=0; mem_we, mem_addr, mem_wdata held stable until mem_ready=1.
//   On handshake cycle: words_written++; next cycle mem_we=0 and
//   idx+1==N -> CHK (or DONE without CHECKSUM_EN), else -> DATA.
//   Minimum 5 cycles per word (4 bytes + 1 write) with mem_ready tied high.
//  DONE: done=1. ERROR: error=1. Both hold until start or reset.
//  cpu_hold = 1 in HDR, DATA, WRITE, CHK; 0 otherwise. Registered outputs only.
//  Gaps in byte_valid stall the FSM with no timeout; byte counter never wraps mid-word.
//  Address arithmetic is 32-bit, wraps modulo 2^32 (not reachable for legal MAX_WORDS).
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined: running 8-bit sum (mod 256) of all DATA bytes
//   (header excluded). After last word, CHK accepts one byte; equal -> DONE,
//   not equal -> ERROR (words already written stay written; words_written = N).
//   N==0 still goes directly to DONE with no checksum byte.
//  Not defined: no CHK state, no sum register; last write goes straight to DONE.
// TESTING
//  Load N=2: bytes 02 00 00 00, 13 00 00 00, 93 00 10 00, mem_ready=1 -> writes
//   (0x0,0x00000013),(0x4,0x00100093); done=1, words_written=2, cpu_hold falls.
//  mem_ready held low 3 cycles during first write -> mem_we/addr/wdata stable 4 cycles,
//   byte_ready=0 throughout, no byte lost when stream resumes.
//  Header N=0 -> DONE next cycle, no mem_we; header N=MAX_WORDS+1 -> error=1, no writes.
//  Assert reset after 6 data bytes -> all outputs to reset values; new start + full
//   image loads correctly from BASE_ADDR.
//  CHECKSUM_EN: image above + byte 0xB6 -> done=1; byte 0xB7 -> error=1, words_written=2.
//  start while busy ignored; start after DONE clears done and reloads a new image.

Source files
------------

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = stream source / memory side.
interface imem_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;

  modport master (
    input  byte_valid, byte_data, mem_ready,
    output byte_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output byte_valid, byte_data, mem_ready,
    input  byte_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed little-endian byte stream into instruction memory, holding the core in reset meanwhile.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing 8-bit sum byte over all data bytes.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  imem_loader_if.master    bus,
  output logic             cpu_hold,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] words_written
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HDR   = 3'd1,
    ST_DATA  = 3'd2,
    ST_WRITE = 3'd3,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHK   = 3'd4,
`endif
    ST_DONE  = 3'd5,
    ST_ERROR = 3'd6
  } state_t;

  state_t           state_r;
  logic [1:0]       byte_cnt_r;
  logic [23:0]      shift_r;
  logic [CNT_W-1:0] len_r;
  logic [CNT_W-1:0] words_r;
  logic             byte_ready_r;
  logic             mem_we_r;
  logic [31:0]      mem_addr_r;
  logic [31:0]      mem_wdata_r;
  logic             cpu_hold_r;
  logic             done_r;
  logic             error_r;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]       sum_r;

  function automatic logic [7:0] sum8(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction
`endif

  logic             byte_fire_s;
  logic [31:0]      word_s;
  logic [CNT_W-1:0] len_s;
  logic [CNT_W-1:0] words_inc_s;
  logic             last_word_s;
  logic [31:0]      addr_s;

  // Byte handshake, word assembly and next-index decode.
  always_comb begin
    byte_fire_s = bus.byte_valid & byte_ready_r;
    word_s      = {bus.byte_data, shift_r};
    len_s       = word_s[CNT_W-1:0];
    words_inc_s = words_r + {{(CNT_W-1){1'b0}}, 1'b1};
    addr_s      = BASE_ADDR + (32'(words_r) << 32'd2);
    if (words_inc_s == len_r) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = 1'b0;
    end
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      byte_cnt_r   <= 2'd0;
      shift_r      <= 24'd0;
      len_r        <= {CNT_W{1'b0}};
      words_r      <= {CNT_W{1'b0}};
      byte_ready_r <= 1'b0;
      mem_we_r     <= 1'b0;
      mem_addr_r   <= BASE_ADDR;
      mem_wdata_r  <= 32'd0;
      cpu_hold_r   <= 1'b0;
      done_r       <= 1'b0;
      error_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      sum_r        <= 8'd0;
`endif
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (start) begin
            state_r      <= ST_HDR;
            byte_cnt_r   <= 2'd0;
            words_r      <= {CNT_W{1'b0}};
            byte_ready_r <= 1'b1;
            cpu_hold_r   <= 1'b1;
            done_r       <= 1'b0;
            error_r      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r        <= 8'd0;
`endif
          end
        end

        ST_HDR: begin
          if (byte_fire_s) begin
            shift_r    <= word_s[31:8];
            byte_cnt_r <= byte_cnt_r + 2'd1;
            if (byte_cnt_r == 2'd3) begin
              len_r <= len_s;
              if (len_s == {CNT_W{1'b0}}) begin
                state_r      <= ST_DONE;
                byte_ready_r <= 1'b0;
                cpu_hold_r   <= 1'b0;
                done_r       <= 1'b1;
              end else if (32'(len_s) > MAX_WORDS) begin
                state_r      <= ST_ERROR;
                byte_ready_r <= 1'b0;
                cpu_hold_r   <= 1'b0;
                error_r      <= 1'b1;
              end else begin
                state_r <= ST_DATA;
              end
            end
          end
        end

        ST_DATA: begin
          if (byte_fire_s) begin
            shift_r    <= word_s[31:8];
            byte_cnt_r <= byte_cnt_r + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_r      <= sum8(sum_r, bus.byte_data);
`endif
            if (byte_cnt_r == 2'd3) begin
              state_r      <= ST_WRITE;
              byte_ready_r <= 1'b0;
              mem_we_r     <= 1'b1;
              mem_wdata_r  <= word_s;
              mem_addr_r   <= addr_s;
            end
          end
        end

        // Request stays frozen until the memory takes it.
        ST_WRITE: begin
          if (bus.mem_ready) begin
            mem_we_r <= 1'b0;
            words_r  <= words_inc_s;
            if (last_word_s) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_r      <= ST_CHK;
              byte_ready_r <= 1'b1;
`else
              state_r      <= ST_DONE;
              cpu_hold_r   <= 1'b0;
              done_r       <= 1'b1;
`endif
            end else begin
              state_r      <= ST_DATA;
              byte_ready_r <= 1'b1;
            end
          end
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        ST_CHK: begin
          if (byte_fire_s) begin
            byte_ready_r <= 1'b0;
            cpu_hold_r   <= 1'b0;
            if (bus.byte_data == sum_r) begin
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ERROR;
              error_r <= 1'b1;
            end
          end
        end
`endif

        default: begin
          state_r      <= ST_IDLE;
          byte_ready_r <= 1'b0;
          mem_we_r     <= 1'b0;
          cpu_hold_r   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.byte_ready = byte_ready_r;
  assign bus.mem_we     = mem_we_r;
  assign bus.mem_addr   = mem_addr_r;
  assign bus.mem_wdata  = mem_wdata_r;
  assign cpu_hold       = cpu_hold_r;
  assign done           = done_r;
  assign error          = error_r;
  assign words_written  = words_r;

endmodule
